// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl - Wishbone GPIO controller with N bidirectional pins.
//
// Pins have a per-pin output enable, an input synchronizer, atomic set/clear
// of the output register, and edge-triggered interrupts with
// write-1-to-clear status.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i               1 = write, 0 = read
//   wb_adr_i              byte address, word index = wb_adr_i[4:2]
//   wb_dat_i / wb_dat_o   write data in / registered read data out
//   wb_ack_o              registered single-cycle acknowledge
//   gpio_i                asynchronous pin inputs
//   gpio_o, gpio_oe       pin output values and output enables
//   irq_o                 OR of all interrupt status bits
//
// Word map: 0 OUT, 1 DIR, 2 IN (RO), 3 SET (WO), 4 CLR (WO), 5 IRQ_EN,
//           6 IRQ_STAT (W1C), 7 IRQ_POL (1 = rising, 0 = falling).
module wb_gpio_ctrl #(
    parameter int N_GPIO      = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [N_GPIO-1:0]     gpio_i,
    output logic [N_GPIO-1:0]     gpio_o,
    output logic [N_GPIO-1:0]     gpio_oe,
    output logic                  irq_o
);

    localparam logic [2:0] IDX_OUT  = 3'd0;
    localparam logic [2:0] IDX_DIR  = 3'd1;
    localparam logic [2:0] IDX_IN   = 3'd2;
    localparam logic [2:0] IDX_SET  = 3'd3;
    localparam logic [2:0] IDX_CLR  = 3'd4;
    localparam logic [2:0] IDX_EN   = 3'd5;
    localparam logic [2:0] IDX_STAT = 3'd6;
    localparam logic [2:0] IDX_POL  = 3'd7;

    logic [N_GPIO-1:0] out_q,      out_d;
    logic [N_GPIO-1:0] dir_q,      dir_d;
    logic [N_GPIO-1:0] irq_en_q,   irq_en_d;
    logic [N_GPIO-1:0] irq_stat_q, irq_stat_d;
    logic [N_GPIO-1:0] irq_pol_q,  irq_pol_d;
    logic [31:0]       dat_q,      dat_d;
    logic              ack_q;

    logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
    logic [N_GPIO-1:0] prev_q;

    logic              req;
    logic [2:0]        idx;
    logic [N_GPIO-1:0] wdat;
    logic [N_GPIO-1:0] sync_val;
    logic [N_GPIO-1:0] hit;
    logic [N_GPIO-1:0] stat_clr;
    logic [31:0]       rdata;

    // Address/data bits outside the decoded range are intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_adr_i, wb_dat_i};

    // The ~ack term makes a held strobe re-arm only after the ack cycle.
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign idx      = wb_adr_i[4:2];
    assign wdat     = wb_dat_i[N_GPIO-1:0];
    assign sync_val = sync_q[SYNC_STAGES-1];
    assign hit      = (irq_pol_q & sync_val & ~prev_q) | (~irq_pol_q & ~sync_val & prev_q);

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        irq_pol_d = irq_pol_q;
        stat_clr = '0;
        rdata    = '0;

        case (idx)
            IDX_OUT:  rdata[N_GPIO-1:0] = out_q;
            IDX_DIR:  rdata[N_GPIO-1:0] = dir_q;
            IDX_IN:   rdata[N_GPIO-1:0] = sync_val;
            IDX_EN:   rdata[N_GPIO-1:0] = irq_en_q;
            IDX_STAT: rdata[N_GPIO-1:0] = irq_stat_q;
            IDX_POL:  rdata[N_GPIO-1:0] = irq_pol_q;
            default:  rdata = '0;
        endcase

        if (req && wb_we_i) begin
            case (idx)
                IDX_OUT:  out_d     = wdat;
                IDX_DIR:  dir_d     = wdat;
                IDX_SET:  out_d     = out_q | wdat;
                IDX_CLR:  out_d     = out_q & ~wdat;
                IDX_EN:   irq_en_d  = wdat;
                IDX_STAT: stat_clr  = wdat;
                IDX_POL:  irq_pol_d = wdat;
                default:  ;
            endcase
        end

        // New hits are OR-ed in after the clear so a colliding edge wins.
        irq_stat_d = (irq_stat_q & ~stat_clr) | (hit & irq_en_q);
        dat_d      = (req && !wb_we_i) ? rdata : dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_pol_q  <= '1;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            sync_q     <= '0;
            prev_q     <= '0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_pol_q  <= irq_pol_d;
            dat_q      <= dat_d;
            ack_q      <= req;
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            end else begin
                sync_q <= gpio_i;
            end
            prev_q     <= sync_val;
        end
    end

    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;
    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign irq_o    = |irq_stat_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Testbench for wb_gpio_ctrl: directed scenarios plus random bus traffic.
// A reference model at each rising edge pushes expected read data into a
// scoreboard queue; a monitor on the falling edge pops on every ack.
module tb_wb_gpio_ctrl;
    localparam int N = 8;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cyc, stb, we;
    logic [31:0]   adr, dat_i;
    logic [31:0]   dat_o;
    logic          ack;
    logic [N-1:0]  gpio_i, gpio_o, gpio_oe;
    logic          irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_gpio_ctrl #(.N_GPIO(N), .ADDR_WIDTH(32), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          rd;
        logic [31:0] d;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] samp[$];      // gpio_i as seen at each rising edge since reset
    logic [N-1:0] m_out, m_dir, m_en, m_stat, m_pol;
    logic [31:0]  m_last_rd;
    bit           m_ack;

    // Input sampled 'back' edges before the most recent one (0 before reset history).
    function automatic logic [N-1:0] hist(input int back);
        if (samp.size() > back) return samp[samp.size() - 1 - back];
        return '0;
    endfunction

    function automatic logic [31:0] m_read(input int ix, input logic [N-1:0] sy);
        logic [N-1:0] v;
        case (ix)
            0: v = m_out;
            1: v = m_dir;
            2: v = sy;
            5: v = m_en;
            6: v = m_stat;
            7: v = m_pol;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    initial begin
        logic [N-1:0] sy, pv, hit, wd, nstat;
        bit           req;
        int           ix;
        exp_t         e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_pol = '1;
                m_last_rd = '0; m_ack = 0;
                sb.delete();
                samp.delete();
            end else begin
                // A pin's synchronized value lags the pin by S edges; prev lags one more.
                sy    = hist(S - 1);
                pv    = hist(S);
                hit   = (m_pol & sy & ~pv) | (~m_pol & ~sy & pv);
                req   = cyc && stb && !m_ack;
                ix    = int'(adr[4:2]);
                wd    = dat_i[N-1:0];
                nstat = m_stat | (hit & m_en);
                if (req) begin
                    e.rd = !we;
                    e.d  = m_read(ix, sy);
                    sb.push_back(e);
                    if (!we) m_last_rd = e.d;
                    else begin
                        case (ix)
                            0: m_out = wd;
                            1: m_dir = wd;
                            3: m_out = m_out | wd;
                            4: m_out = m_out & ~wd;
                            5: m_en  = wd;
                            6: nstat = (m_stat & ~wd) | (hit & m_en);
                            7: m_pol = wd;
                            default: ;
                        endcase
                    end
                end
                m_stat = nstat;
                m_ack  = req;
                samp.push_back(gpio_i);
                while (samp.size() > S + 1) void'(samp.pop_front());
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("ack_level", ack, m_ack);
            if (ack) begin
                chk("ack_without_request", {31'b0, sb.size() == 0}, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (e.rd) chk("read_data", dat_o, e.d);
                end
            end
            chk("dat_o_hold", dat_o, m_last_rd);
            chk("gpio_o", gpio_o, m_out);
            chk("gpio_oe", gpio_oe, m_dir);
            chk("irq_o", irq, |m_stat);
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; returns at a falling edge with the bus idle.
    task automatic xfer(input bit w, input int ix, input logic [31:0] d, output logic [31:0] rd);
        int n;
        cyc = 1; stb = 1; we = w; adr = 32'(ix) << 2; dat_i = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 5);
        chk("ack_latency", n, 1);
        rd = dat_o;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        bit          pat[6];
        cyc = 0; stb = 0; we = 0; adr = '0; dat_i = '0; gpio_i = '0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Build up non-zero state, then reset asynchronously mid-transaction.
        xfer(1, 0, 32'hFF, rd);
        xfer(1, 1, 32'hFF, rd);
        xfer(1, 5, 32'h01, rd);
        gpio_i = 8'h01;
        repeat (S + 2) @(negedge clk);
        chk("irq_before_reset", irq, 1);
        cyc = 1; stb = 1; we = 1; adr = 32'h0; dat_i = 32'h0;
        @(posedge clk); #2;
        chk("ack_before_reset", ack, 1);
        rst = 1; #1;
        chk("rst_async_gpio_o", gpio_o, 0);
        chk("rst_async_gpio_oe", gpio_oe, 0);
        chk("rst_async_ack", ack, 0);
        chk("rst_async_irq", irq, 0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst = 0; gpio_i = '0;
        @(negedge clk);

        // Write pending when reset hits is lost and never acked.
        cyc = 1; stb = 1; we = 1; adr = 32'h0; dat_i = 32'h55;
        #2 rst = 1;
        @(posedge clk); #1;
        chk("rst_pending_ack", ack, 0);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0; rst = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            xfer(0, i, 0, rd);
            chk($sformatf("reset_val_%0d", i), rd, (i == 7) ? 32'h0000_00FF : 32'h0);
        end

        // Set / clear atomicity.
        xfer(1, 0, 32'h0F, rd);
        xfer(1, 3, 32'h30, rd);
        xfer(1, 4, 32'h03, rd);
        chk("set_clr_gpio_o", gpio_o, 8'h3C);
        xfer(0, 3, 0, rd); chk("read_set_zero", rd, 0);
        xfer(0, 4, 0, rd); chk("read_clr_zero", rd, 0);

        // Input synchronizer latency: read d edges after the change.
        for (int d = 0; d <= S + 1; d++) begin
            gpio_i = '0;
            repeat (S + 2) @(negedge clk);
            gpio_i = 8'hA5;
            repeat (d) @(negedge clk);
            xfer(0, 2, 0, rd);
            chk($sformatf("in_latency_d%0d", d), rd, (d >= S) ? 32'hA5 : 32'h0);
        end
        xfer(1, 2, 32'hFF, rd);
        xfer(0, 2, 0, rd);
        chk("in_write_ignored", rd, 32'hA5);

        // Edge interrupts.
        gpio_i = 8'h02;
        repeat (S + 2) @(negedge clk);
        xfer(1, 7, 32'h01, rd);
        xfer(1, 5, 32'h03, rd);
        xfer(1, 6, 32'hFF, rd);
        gpio_i = 8'h01;
        repeat (S + 2) @(negedge clk);
        xfer(0, 6, 0, rd);
        chk("irq_stat_both", rd, 32'h03);
        chk("irq_o_set", irq, 1);
        gpio_i = 8'h05;
        repeat (S + 2) @(negedge clk);
        gpio_i = 8'h01;
        repeat (S + 2) @(negedge clk);
        xfer(0, 6, 0, rd);
        chk("irq_disabled_pin", rd, 32'h03);
        xfer(1, 6, 32'h01, rd);
        xfer(0, 6, 0, rd);
        chk("irq_w1c", rd, 32'h02);
        chk("irq_o_after_w1c", irq, 1);

        // W1C on the same edge a new rising edge sets bit 0.
        gpio_i = 8'h00;
        repeat (S + 2) @(negedge clk);
        gpio_i = 8'h01;
        repeat (S) @(negedge clk);
        xfer(1, 6, 32'h01, rd);
        xfer(0, 6, 0, rd);
        chk("w1c_collision", rd, 32'h03);

        // Held strobe on a read of OUT.
        pat = '{0, 1, 0, 1, 0, 1};
        cyc = 1; stb = 1; we = 0; adr = 32'h0;
        for (int j = 0; j < 6; j++) begin
            if (j == 0) #1;
            else begin
                @(posedge clk); #1;
            end
            chk($sformatf("held_ack_%0d", j), ack, pat[j]);
            if (ack) chk($sformatf("held_data_%0d", j), dat_o, 32'h3C);
        end
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = N'($urandom);
            xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, rd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_gpio_ctrl.md
# wb_gpio_ctrl

Parametrised Wishbone GPIO controller with N bidirectional pins. Each pin has an output-enable and an input synchronizer. Outputs can be set or cleared atomically. Pins can raise edge-triggered interrupts with write-1-to-clear status. It sits on the system Wishbone interconnect as a slave next to the RAM and UART slaves, and it replaces the fixed 5-LED GPIO slave.

## Interface
- N_GPIO, 8: number of pins, 1..32.
- ADDR_WIDTH, 32: width of wb_adr_i; only bits [4:2] are decoded.
- SYNC_STAGES, 2: input synchronizer depth, ≥2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_WIDTH  byte address; word index = wb_adr_i[4:2].
- wb_dat_i  in  32  write data; bits [31:N_GPIO] ignored.
- wb_dat_o  out  32  registered read data; bits [31:N_GPIO] read 0.
- wb_ack_o  out  1  registered single-cycle acknowledge.
- gpio_i  in  N_GPIO  asynchronous pin inputs.
- gpio_o  out  N_GPIO  pin output values (OUT register).
- gpio_oe  out  N_GPIO  per-pin output enable (DIR register); 1 = drive.
- irq_o  out  1  OR of all IRQ_STAT bits.

## Operation
- Register map, by word index:
  - 0 OUT (RW)
  - 1 DIR (RW)
  - 2 IN (RO, synchronized gpio_i)
  - 3 SET (WO, OUT |= data, reads 0)
  - 4 CLR (WO, OUT &= ~data, reads 0)
  - 5 IRQ_EN (RW)
  - 6 IRQ_STAT (R, write-1-to-clear)
  - 7 IRQ_POL (RW; 1 = rising edge, 0 = falling edge)
- Writes to RO registers are acknowledged and have no effect.
- Request condition: req = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- On req, at the next edge:
  - wb_ack_o goes to 1.
  - A write updates the addressed register.
  - A read loads wb_dat_o with the addressed register's current value.
- wb_ack_o is high for exactly one cycle, then returns to 0 even if stb is still high. Back-to-back accesses therefore complete every 2 cycles.
- wb_dat_o holds its value between reads and is unchanged by writes.
- Input path: gpio_i passes through SYNC_STAGES flops to give sync. A further flop holds prev.
- Edge detection, per bit:
  - rise = sync & ~prev
  - fall = ~sync & prev
  - hit = IRQ_POL ? rise : fall
- IRQ_STAT bit sets when hit & IRQ_EN is true. Disabled pins never set status.
- Lowering IRQ_EN does not clear status bits already set.
- Simultaneous W1C and a new hit on the same bit: set wins, so the bit stays 1.
- IN reads return sync, not prev.
- Reset values:
  - OUT, DIR, IRQ_EN, IRQ_STAT, sync chain and prev are all 0.
  - IRQ_POL resets to all-ones (rising).
  - gpio_o, gpio_oe, wb_dat_o, wb_ack_o and irq_o are all 0.
- Reset asserted mid-transaction: ack is dropped immediately, the pending write is lost, and no ack is issued for it.

## Timing
- Access latency: ack 1 cycle after the first cycle of stb.
- Register write visibility: gpio_o and gpio_oe change on the same edge that raises wb_ack_o.
- Input latency:
  - A gpio_i change stable before edge k is readable in IN from edge k+SYNC_STAGES-1 onward.
  - The resulting IRQ_STAT bit sets at edge k+SYNC_STAGES.
- irq_o is combinational from the IRQ_STAT flops (OR-reduce), so it rises in the same cycle as the status bit.
- A read of IRQ_STAT returns the value before any same-edge update.
- Pulses on gpio_i shorter than one clock period may be missed; this is acceptable.

## Test plan
- Reset and defaults: assert rst asynchronously mid-cycle. Required:
  - gpio_o, gpio_oe, wb_ack_o and irq_o go to 0 without a clock edge.
  - After release, reading index 7 returns 0x000000FF (N_GPIO=8) and all other indices return 0.
- Set/clear atomicity: write OUT=0x0F, SET 0x30, CLR 0x03. Required:
  - gpio_o = 0x3C.
  - Reads of SET and CLR return 0.
  - Each access acks exactly 1 cycle after stb rises and holds ack for 1 cycle.
- Input sync: drive gpio_i=0xA5 and read IN continuously. Required:
  - 0xA5 appears exactly SYNC_STAGES edges later.
  - Writing index 2 leaves IN unchanged.
- Edge interrupts: IRQ_EN=0x03 and IRQ_POL=0x01, then toggle gpio_i[0] 0→1 and gpio_i[1] 1→0. Required:
  - IRQ_STAT = 0x03 and irq_o=1.
  - Toggling gpio_i[2] does not set bit 2.
  - Writing 0x01 to IRQ_STAT leaves 0x02, and irq_o stays 1.
- W1C/set collision: time the W1C of bit 0 on the same edge as a new rising edge on pin 0. Required: bit 0 remains 1.
- Held strobe: keep cyc/stb high for 6 cycles with a read. Required:
  - ack pattern 0,1,0,1,0,1.
  - wb_dat_o stable and correct on each ack.
